fetch_unit: RTL



---
 rtl/fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the RAM fetch address, buffers {pc, instr} pairs in a small FIFO
// and hands them to decode over valid/ready. Optional macro FETCH_MISALIGN_CHECK_EN halts on misaligned redirects.
module fetch_unit #(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ADDR_WIDTH = 16,
  parameter int                     FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  misalign_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_halted;
  logic [ADDR_WIDTH-1:0] w_load_pc;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {S_RUN, S_HALTED} state_t;
  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) w_state_next = S_HALTED;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_RUN;
    endcase
  end

  // HALTED is entered only by a misaligned redirect and left only by reset, so it doubles as the sticky flag
  assign w_halted     = (r_state == S_HALTED);
  assign misalign_err = w_halted;
  assign w_load_pc    = redirect_pc;
`else
  assign w_halted     = 1'b0;
  assign misalign_err = 1'b0;
  assign w_load_pc    = redirect_pc & ~ADDR_WIDTH'(3);
`endif

  assign i_address = r_fetch_pc;
  assign w_empty   = (r_count == '0);
  assign out_valid = ~w_empty & ~redirect_valid;
  assign out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign out_instr = w_empty ? '0 : r_instr_mem[r_rd_ptr];
  assign w_pop     = out_valid & out_ready;
  assign w_fetch   = ~redirect_valid & ~w_halted & ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_load_pc;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_fetch) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_fetch) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_fetch) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= i_read_data;
    end
  end

endmodule
